// File: rtl/ocr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ocr_pkg
// Brief    : Shared types and constants for the OCR image load / BNN path.
// Revision : 1.0 - initial release
// ============================================================================
package ocr_pkg;

    // Payload bytes per image: 904 bits, of which 900 carry pixels.
    localparam int IMG_BYTES_DEFAULT = 113;

    // Command bytes recognised while idle.
    localparam logic [7:0] CMD_LOAD  = 8'hA5;
    localparam logic [7:0] CMD_CLEAR = 8'hC3;

    // Classification result produced by the BNN core.
    typedef logic [3:0] class_t;

    // Sequencer states, explicitly encoded.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_FULL = 3'd2,
        ST_START     = 3'd3,
        ST_INFER     = 3'd4,
        ST_SEND      = 3'd5,
        ST_CLEAR     = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/timeout_counter.sv
`default_nettype none
// ============================================================================
// Module   : timeout_counter
// Brief    : Saturating idle-cycle counter. Flags expiry once the count
//            reaches LIMIT-1; clear has priority over enable. LIMIT >= 2.
// Revision : 1.0 - initial release
// ============================================================================
module timeout_counter #(
    parameter int LIMIT = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int              CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0]   LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q;

    // Count enabled idle cycles, holding at LAST so the counter never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (enable_i && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/image_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : image_load_sequencer
// Brief    : Command parser and load/infer/reply sequencer between the byte
//            receiver, the image buffer and the BNN core. IMG_BYTES <= 127.
// Revision : 1.0 - initial release
// ============================================================================
module image_load_sequencer
    import ocr_pkg::*;
#(
    parameter int IMG_BYTES      = IMG_BYTES_DEFAULT,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic [7:0] buf_data,
    output logic       buf_write_request,
    output logic       buf_clear,
    input  logic       buf_write_ready,
    input  logic       buf_full,
    output logic       bnn_start,
    input  logic       bnn_done,
    input  logic [3:0] bnn_result,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic       busy,
    output logic       err_timeout,
    output logic       err_overrun
);

    localparam logic [6:0] LAST_BYTE = 7'(IMG_BYTES - 1);

    state_t     state_q, state_d;
    logic [6:0] byte_cnt_q, byte_cnt_d;
    class_t     result_q, result_d;
    logic       err_timeout_d;
    logic       err_overrun_d;
    logic       byte_accept;
    logic       tmo_clear;
    logic       tmo_enable;
    logic       tmo_expired;

    // Idle-gap watchdog for the load phase; held cleared outside LOAD so it
    // always starts from zero when a load begins.
    timeout_counter #(
        .LIMIT     (TIMEOUT_CYCLES)
    ) u_load_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (tmo_clear),
        .enable_i  (tmo_enable),
        .expired_o (tmo_expired)
    );

    // Next-state logic: command decode, payload counting, handshakes.
    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        result_d      = result_q;
        err_timeout_d = err_timeout;
        err_overrun_d = err_overrun;
        byte_accept   = 1'b0;
        tmo_clear     = 1'b1;
        tmo_enable    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid && (rx_data == CMD_LOAD)) begin
                    state_d       = ST_LOAD;
                    byte_cnt_d    = '0;
                    err_timeout_d = 1'b0;
                    err_overrun_d = 1'b0;
                end else if (rx_valid && (rx_data == CMD_CLEAR)) begin
                    state_d       = ST_CLEAR;
                    err_timeout_d = 1'b0;
                    err_overrun_d = 1'b0;
                end
            end
            ST_LOAD: begin
                // Every byte is payload here; an arriving byte beats expiry.
                tmo_clear = 1'b0;
                if (rx_valid) begin
                    if (buf_write_ready) begin
                        byte_accept = 1'b1;
                        tmo_clear   = 1'b1;
                        byte_cnt_d  = byte_cnt_q + 7'd1;
                        if (byte_cnt_q == LAST_BYTE) begin
                            state_d = ST_WAIT_FULL;
                        end
                    end else begin
                        err_overrun_d = 1'b1;
                    end
                end else if (tmo_expired) begin
                    err_timeout_d = 1'b1;
                    state_d       = ST_CLEAR;
                end else begin
                    tmo_enable = 1'b1;
                end
            end
            ST_WAIT_FULL: begin
                if (buf_full) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_INFER;
            end
            ST_INFER: begin
                if (bnn_done) begin
                    result_d = bnn_result;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and every output register; outputs derive from the
    // next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= ST_IDLE;
            byte_cnt_q        <= '0;
            result_q          <= '0;
            buf_data          <= '0;
            buf_write_request <= 1'b0;
            buf_clear         <= 1'b0;
            bnn_start         <= 1'b0;
            tx_valid          <= 1'b0;
            tx_data           <= '0;
            busy              <= 1'b0;
            err_timeout       <= 1'b0;
            err_overrun       <= 1'b0;
        end else begin
            state_q           <= state_d;
            byte_cnt_q        <= byte_cnt_d;
            result_q          <= result_d;
            buf_write_request <= byte_accept;
            if (byte_accept) begin
                buf_data <= rx_data;
            end
            buf_clear         <= (state_d == ST_CLEAR);
            bnn_start         <= (state_d == ST_START);
            tx_valid          <= (state_d == ST_SEND);
            tx_data           <= (state_d == ST_SEND) ? {4'h0, result_d} : 8'h00;
            busy              <= (state_d != ST_IDLE);
            err_timeout       <= err_timeout_d;
            err_overrun       <= err_overrun_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_image_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_image_load_sequencer
// Brief    : Directed self-checking bench for image_load_sequencer with a
//            small behavioural image-buffer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_image_load_sequencer;

    localparam int IMG = 113;
    localparam int TMO = 100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [7:0] buf_data;
    logic       buf_write_request;
    logic       buf_clear;
    logic       buf_write_ready;
    logic       buf_full;
    logic       bnn_start;
    logic       bnn_done;
    logic [3:0] bnn_result;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       busy;
    logic       err_timeout;
    logic       err_overrun;

    int errors = 0;
    int checks = 0;

    logic [7:0] model_wr_cnt;

    always #5 clk = ~clk;

    image_load_sequencer #(
        .IMG_BYTES         (IMG),
        .TIMEOUT_CYCLES    (TMO)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rx_valid          (rx_valid),
        .rx_data           (rx_data),
        .buf_data          (buf_data),
        .buf_write_request (buf_write_request),
        .buf_clear         (buf_clear),
        .buf_write_ready   (buf_write_ready),
        .buf_full          (buf_full),
        .bnn_start         (bnn_start),
        .bnn_done          (bnn_done),
        .bnn_result        (bnn_result),
        .tx_valid          (tx_valid),
        .tx_data           (tx_data),
        .tx_ready          (tx_ready),
        .busy              (busy),
        .err_timeout       (err_timeout),
        .err_overrun       (err_overrun)
    );

    // Image buffer model: counts write strobes, reports full one cycle after
    // the last strobe, empties on clear or reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_wr_cnt <= 8'd0;
        end else if (buf_clear) begin
            model_wr_cnt <= 8'd0;
        end else if (buf_write_request) begin
            model_wr_cnt <= model_wr_cnt + 8'd1;
        end
    end

    assign buf_full = (model_wr_cnt >= 8'(IMG));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_buf_data"},  32'(buf_data), 32'h0);
        check({tag, "_wr_req"},    32'(buf_write_request), 32'h0);
        check({tag, "_buf_clear"}, 32'(buf_clear), 32'h0);
        check({tag, "_bnn_start"}, 32'(bnn_start), 32'h0);
        check({tag, "_tx_valid"},  32'(tx_valid), 32'h0);
        check({tag, "_tx_data"},   32'(tx_data), 32'h0);
        check({tag, "_busy"},      32'(busy), 32'h0);
        check({tag, "_err_tmo"},   32'(err_timeout), 32'h0);
        check({tag, "_err_ovr"},   32'(err_overrun), 32'h0);
    endtask

    // One-cycle rx strobe; returns at the negedge after the sampling edge.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    // Payload byte whose write strobe must appear exactly one cycle later.
    task automatic send_payload(input logic [7:0] b);
        send_byte(b);
        check("wr_strobe", 32'(buf_write_request), 32'h1);
        check("wr_data",   32'(buf_data), 32'(b));
    endtask

    // After the final payload byte: strobe drops, then one bnn_start pulse.
    task automatic expect_start();
        int n = 0;
        @(negedge clk);
        check("wr_strobe_off", 32'(buf_write_request), 32'h0);
        while (bnn_start !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bnn_start_seen", 32'(bnn_start), 32'h1);
        check("wr_count", 32'(model_wr_cnt), 32'(IMG));
        @(negedge clk);
        check("bnn_start_one_cycle", 32'(bnn_start), 32'h0);
        check("busy_infer", 32'(busy), 32'h1);
    endtask

    // Deliver a result, hold tx_ready low for 'hold' cycles, then complete.
    task automatic finish_infer(input logic [3:0] res, input int hold);
        bnn_done   = 1'b1;
        bnn_result = res;
        @(negedge clk);
        bnn_done   = 1'b0;
        bnn_result = 4'h0;
        for (int i = 0; i < hold; i++) begin
            check("tx_valid_hold", 32'(tx_valid), 32'h1);
            check("tx_data_hold",  32'(tx_data), {28'h0, res});
            @(negedge clk);
        end
        check("tx_valid", 32'(tx_valid), 32'h1);
        check("tx_data",  32'(tx_data), {28'h0, res});
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        check("clear_after_tx",  32'(buf_clear), 32'h1);
        check("tx_valid_drop",   32'(tx_valid), 32'h0);
        @(negedge clk);
        check("clear_one_cycle", 32'(buf_clear), 32'h0);
        check("busy_done",       32'(busy), 32'h0);
        check("buf_emptied",     32'(buf_full), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n           = 1'b0;
        rx_valid        = 1'b0;
        rx_data         = 8'h00;
        buf_write_ready = 1'b1;
        bnn_done        = 1'b0;
        bnn_result      = 4'h0;
        tx_ready        = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Unknown byte ignored, CLEAR command gives a single clear pulse.
        send_byte(8'h5A);
        check("ignore_busy",  32'(busy), 32'h0);
        check("ignore_clear", 32'(buf_clear), 32'h0);
        send_byte(8'hC3);
        check("cmd_clear_pulse", 32'(buf_clear), 32'h1);
        check("cmd_clear_busy",  32'(busy), 32'h1);
        @(negedge clk);
        check("cmd_clear_end",   32'(buf_clear), 32'h0);
        check("cmd_clear_idle",  32'(busy), 32'h0);

        // bnn_done while idle is ignored.
        bnn_done   = 1'b1;
        bnn_result = 4'h9;
        @(negedge clk);
        bnn_done   = 1'b0;
        bnn_result = 4'h0;
        check("stray_done_busy", 32'(busy), 32'h0);
        check("stray_done_tx",   32'(tx_valid), 32'h0);

        // Full image 0x00..0x70, inference, result held under back-pressure.
        send_byte(8'hA5);
        check("load_busy", 32'(busy), 32'h1);
        for (int i = 0; i < IMG; i++) send_payload(8'(i));
        expect_start();
        finish_infer(4'd7, 5);

        // 50 bytes then silence: timeout fires 100 cycles after the last byte.
        send_byte(8'hA5);
        for (int i = 0; i < 50; i++) send_payload(8'(8'hF0 - i));
        repeat (TMO - 1) @(negedge clk);
        check("tmo_not_yet",  32'(err_timeout), 32'h0);
        check("tmo_busy",     32'(busy), 32'h1);
        @(negedge clk);
        check("tmo_flag",     32'(err_timeout), 32'h1);
        check("tmo_clear",    32'(buf_clear), 32'h1);
        @(negedge clk);
        check("tmo_idle",     32'(busy), 32'h0);
        check("tmo_clear_end", 32'(buf_clear), 32'h0);
        check("tmo_sticky",   32'(err_timeout), 32'h1);
        check("tmo_buf_empty", 32'(model_wr_cnt), 32'h0);

        // New load clears the flag; an overrun byte is dropped uncounted.
        send_byte(8'hA5);
        check("tmo_cleared_by_load", 32'(err_timeout), 32'h0);
        buf_write_ready = 1'b0;
        send_byte(8'hEE);
        check("ovr_flag",     32'(err_overrun), 32'h1);
        check("ovr_no_write", 32'(buf_write_request), 32'h0);
        buf_write_ready = 1'b1;
        for (int i = 0; i < IMG; i++) send_payload(8'(i) ^ 8'h3C);
        expect_start();
        check("ovr_sticky", 32'(err_overrun), 32'h1);
        finish_infer(4'hB, 0);

        // Asynchronous reset mid-load at byte 60, then a clean full run.
        send_byte(8'hA5);
        for (int i = 0; i < 60; i++) send_payload(8'(i + 1));
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'hA5);
        for (int i = 0; i < IMG; i++) send_payload(8'(8'h80 + i));
        expect_start();
        finish_infer(4'd3, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
